shift_add_ctrl: RTL and testbench

//  Control and accumulator stage of the shift-add multiplier. Sits upstream of
//  the N-bit universal shift register that holds the multiplier (Q) operand:

---
 rtl/shift_add_ctrl_if.sv | 29 ++
 rtl/shift_add_ctrl.sv | 110 +++++++++++
 tb/tb_shift_add_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_ctrl_if.sv
// Interface for the shift-add multiplier controller: start/busy/done handshake,
// operands and product, plus the link to the external Q shift register.
// Signal names are from the controller's point of view.
interface shift_add_ctrl_if #(
  parameter int N = 4
);
  logic           i_start;
  logic [N-1:0]   i_multiplicand;
  logic [N-1:0]   i_multiplier;
  logic [N-1:0]   i_sr_q;
  logic [1:0]     o_sr_ctrl;
  logic [N-1:0]   o_sr_parallel_in;
  logic           o_sr_ser_in;
  logic           o_busy;
  logic           o_done;
  logic [2*N-1:0] o_product;

  // Surrounding system and shift register side.
  modport master (
    output i_start, i_multiplicand, i_multiplier, i_sr_q,
    input  o_sr_ctrl, o_sr_parallel_in, o_sr_ser_in, o_busy, o_done, o_product
  );

  // Controller side.
  modport slave (
    input  i_start, i_multiplicand, i_multiplier, i_sr_q,
    output o_sr_ctrl, o_sr_parallel_in, o_sr_ser_in, o_busy, o_done, o_product
  );
endinterface

// File: rtl/shift_add_ctrl.sv
// Control and accumulator stage of an unsigned shift-add multiplier.
// Holds the multiplicand (M) and high product half (A); the multiplier (Q)
// lives in an external universal shift register driven through the bus.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | waiting for start; operands captured on acceptance
//  S_LOAD | load Q into the shift register, clear A and step counter
//  S_CALC | N add/shift steps; sum LSB shifts into Q's MSB
//  S_DONE | capture {A, Q} into product, raise done for the next cycle
module shift_add_ctrl #(
  parameter int N = 4
) (
  input logic           clk,
  input logic           rst,
  shift_add_ctrl_if.slave bus
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_m;
  logic [N-1:0]     r_mq;
  logic [N-1:0]     r_a;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [2*N-1:0]   r_product;

  logic [N-1:0]     w_addend;
  logic [N:0]       w_sum;

  // Add path is one bit wider than A so the carry lands in A's MSB after the shift.
  always_comb begin
    w_addend = bus.i_sr_q[0] ? r_m : '0;
    w_sum    = {1'b0, r_a} + {1'b0, w_addend};
  end

  // Shift register control and busy decode straight from the state.
  always_comb begin
    bus.o_sr_ctrl        = 2'b00;
    bus.o_sr_parallel_in = '0;
    bus.o_sr_ser_in      = 1'b0;
    bus.o_busy           = (r_state != S_IDLE);
    case (r_state)
      S_LOAD: begin
        bus.o_sr_ctrl        = 2'b11;
        bus.o_sr_parallel_in = r_mq;
      end
      S_CALC: begin
        bus.o_sr_ctrl   = 2'b01;
        bus.o_sr_ser_in = w_sum[0];
      end
      default: ;
    endcase
  end

  assign bus.o_done    = r_done;
  assign bus.o_product = r_product;

  // Sequencer, operand capture, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_mq      <= '0;
      r_a       <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_m     <= bus.i_multiplicand;
            r_mq    <= bus.i_multiplier;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_a     <= '0;
          r_cnt   <= '0;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_a   <= w_sum[N:1];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_product <= {r_a, bus.i_sr_q};
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Bench for shift_add_ctrl: N=4 and N=8 instances, each closed around a
// behavioural universal shift register holding Q.
module tb_shift_add_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_add_ctrl_if #(.N(4)) if4 ();
  shift_add_ctrl_if #(.N(8)) if8 ();

  shift_add_ctrl #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  shift_add_ctrl #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  logic [3:0] sr4;
  logic [7:0] sr8;

  // Q shift registers: 11 load, 01 shift right with ser_in at MSB, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr4 <= '0;
      sr8 <= '0;
    end else begin
      case (if4.o_sr_ctrl)
        2'b11:   sr4 <= if4.o_sr_parallel_in;
        2'b01:   sr4 <= {if4.o_sr_ser_in, sr4[3:1]};
        default: sr4 <= sr4;
      endcase
      case (if8.o_sr_ctrl)
        2'b11:   sr8 <= if8.o_sr_parallel_in;
        2'b01:   sr8 <= {if8.o_sr_ser_in, sr8[7:1]};
        default: sr8 <= sr8;
      endcase
    end
  end

  assign if4.i_sr_q = sr4;
  assign if8.i_sr_q = sr8;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  logic [1:0] ctrl_log [16];
  logic       busy_log [16];
  logic [3:0] pin_log  [16];

  // One N=4 multiply; optionally pulses start (2 x 2) after edge restart_at.
  task automatic run4(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                      input int restart_at);
    int lat;
    int extra;
    logic [7:0] prod;
    lat  = -1;
    prod = '0;
    @(negedge clk);
    if4.i_start        = 1'b1;
    if4.i_multiplicand = m;
    if4.i_multiplier   = q;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      ctrl_log[k] = if4.o_sr_ctrl;
      busy_log[k] = if4.o_busy;
      pin_log[k]  = if4.o_sr_parallel_in;
      if (if4.o_done && lat < 0) begin
        lat  = k;
        prod = if4.o_product;
      end
      @(negedge clk);
      if (k == restart_at) begin
        if4.i_start        = 1'b1;
        if4.i_multiplicand = 4'd2;
        if4.i_multiplier   = 4'd2;
      end else begin
        if4.i_start        = 1'b0;
        if4.i_multiplicand = ~m;
        if4.i_multiplier   = ~q;
      end
      if (lat >= 0) break;
    end
    if (lat < 0) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("product", 32'(prod), 32'(exp));
      chk("latency_edges", 32'(lat), 32'd6);
      chk("sr_ctrl_seq", 32'({ctrl_log[0], ctrl_log[1], ctrl_log[2],
                              ctrl_log[3], ctrl_log[4], ctrl_log[5]}),
          32'(12'b11_01_01_01_01_00));
      chk("busy_seq", 32'({busy_log[0], busy_log[1], busy_log[2], busy_log[3],
                           busy_log[4], busy_log[5], busy_log[6]}), 32'(7'b1111110));
      chk("load_value", 32'(pin_log[0]), 32'(q));
    end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (if4.o_done) extra++;
    end
    chk("no_extra_done", 32'(extra), 32'd0);
    chk("product_held", 32'(if4.o_product), 32'(exp));
  endtask

  task automatic chk_idle4(input string tag);
    chk({tag, "_busy"},   32'(if4.o_busy), 32'd0);
    chk({tag, "_done"},   32'(if4.o_done), 32'd0);
    chk({tag, "_prod"},   32'(if4.o_product), 32'd0);
    chk({tag, "_ctrl"},   32'(if4.o_sr_ctrl), 32'd0);
    chk({tag, "_pin"},    32'(if4.o_sr_parallel_in), 32'd0);
    chk({tag, "_serin"},  32'(if4.o_sr_ser_in), 32'd0);
  endtask

  initial begin
    int lat1;
    int lat2;
    int n_done;
    logic [15:0] p1;
    logic [15:0] p2;

    vecs[0] = '{m: 4'd13, q: 4'd11, exp: 8'd143};
    vecs[1] = '{m: 4'd15, q: 4'd15, exp: 8'd225};
    vecs[2] = '{m: 4'd0,  q: 4'd9,  exp: 8'd0};
    vecs[3] = '{m: 4'd9,  q: 4'd0,  exp: 8'd0};
    vecs[4] = '{m: 4'd1,  q: 4'd15, exp: 8'd15};
    vecs[5] = '{m: 4'd15, q: 4'd1,  exp: 8'd15};
    vecs[6] = '{m: 4'd10, q: 4'd12, exp: 8'd120};
    vecs[7] = '{m: 4'd11, q: 4'd14, exp: 8'd154};

    rst = 1'b1;
    if4.i_start = 1'b0; if4.i_multiplicand = '0; if4.i_multiplier = '0;
    if8.i_start = 1'b0; if8.i_multiplicand = '0; if8.i_multiplier = '0;
    repeat (2) @(negedge clk);
    chk_idle4("reset");
    chk("reset8_busy", 32'(if8.o_busy), 32'd0);
    chk("reset8_prod", 32'(if8.o_product), 32'd0);
    chk("reset8_ctrl", 32'(if8.o_sr_ctrl), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run4(vecs[i].m, vecs[i].q, vecs[i].exp, -1);
    end

    // start pulsed with 2 x 2 while in CALC must be ignored
    run4(4'd7, 4'd5, 8'd35, 2);

    // reset during the third CALC cycle aborts with no done
    @(negedge clk);
    if4.i_start = 1'b1; if4.i_multiplicand = 4'd7; if4.i_multiplier = 4'd3;
    @(posedge clk);
    @(negedge clk);
    if4.i_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_abort_busy", 32'(if4.o_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_idle4("abort");
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (if4.o_done || if4.o_busy) n_done++;
    end
    chk("abort_quiet", 32'(n_done), 32'd0);
    run4(4'd6, 4'd7, 8'd42, -1);

    // N=8: 255 x 255, then back-to-back 3 x 4 started in the done cycle
    lat1 = -1; lat2 = -1; p1 = '0; p2 = '0; n_done = 0;
    @(negedge clk);
    if8.i_start = 1'b1; if8.i_multiplicand = 8'd255; if8.i_multiplier = 8'd255;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (if8.o_done) begin
        n_done++;
        if (lat1 < 0) begin
          lat1 = k; p1 = if8.o_product;
        end else if (lat2 < 0) begin
          lat2 = k; p2 = if8.o_product;
        end
      end
      @(negedge clk);
      if (k == lat1) begin
        if8.i_start = 1'b1; if8.i_multiplicand = 8'd3; if8.i_multiplier = 8'd4;
      end else begin
        if8.i_start = 1'b0; if8.i_multiplicand = 8'hA5; if8.i_multiplier = 8'h5A;
      end
      if (lat2 >= 0) break;
    end
    chk("n8_lat1", 32'(lat1), 32'd10);
    chk("n8_prod1", 32'(p1), 32'd65025);
    chk("n8_lat2", 32'(lat2), 32'd21);
    chk("n8_prod2", 32'(p2), 32'd12);
    chk("n8_done_count", 32'(n_done), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
